// File: rtl/udb_seq.sv
// Command sequencer for the udb up/down counter: turns LOAD / COUNT / HOLD commands into
// counter load, direction and enable controls, and reports done, wrap and abort status.
module udb_seq #(
  parameter int unsigned WIDTH    = 16,
  parameter logic [3:0]  DIR_UP   = 4'h1,
  parameter logic [3:0]  DIR_DOWN = 4'h0
) (
  input  logic             udb_seq_clk,
  input  logic             udb_seq_rst,
  input  logic             udb_seq_cmd_valid,
  output logic             udb_seq_cmd_ready,
  input  logic [1:0]       udb_seq_cmd_op,
  input  logic [WIDTH-1:0] udb_seq_cmd_data,
  input  logic             udb_seq_abort,
  input  logic [WIDTH-1:0] udb_seq_q,
  output logic             udb_seq_load,
  output logic [WIDTH-1:0] udb_seq_load_value,
  output logic [3:0]       udb_seq_direction,
  output logic             udb_seq_en,
  output logic             udb_seq_busy,
  output logic             udb_seq_done,
  output logic             udb_seq_wrap,
  output logic             udb_seq_aborted,
  output logic [WIDTH-1:0] udb_seq_steps_left
);

  typedef enum logic [2:0] {StIdle, StLoad, StCount, StHold, StDone} state_e;

  localparam logic [1:0] OpLoad = 2'b00;
  localparam logic [1:0] OpUp   = 2'b01;
  localparam logic [1:0] OpDown = 2'b10;

  state_e           state_q, state_d;
  logic             ready_q, ready_d;
  logic             load_q, load_d;
  logic [WIDTH-1:0] load_value_q, load_value_d;
  logic [3:0]       direction_q, direction_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             wrap_q, wrap_d;
  logic             aborted_q, aborted_d;
  logic [WIDTH-1:0] steps_q, steps_d;

  logic last_step;
  logic at_wrap;

  assign last_step = (steps_q == WIDTH'(1));
  assign at_wrap   = ((direction_q == DIR_UP) && (udb_seq_q == '1)) ||
                     ((direction_q == DIR_DOWN) && (udb_seq_q == '0));

  always_comb begin
    state_d      = state_q;
    ready_d      = ready_q;
    load_d       = 1'b0;
    load_value_d = load_value_q;
    direction_d  = direction_q;
    en_d         = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    wrap_d       = wrap_q;
    aborted_d    = aborted_q;
    steps_d      = steps_q;

    unique case (state_q)
      StIdle: begin
        ready_d = 1'b1;
        if (udb_seq_cmd_valid && ready_q) begin
          ready_d   = 1'b0;
          busy_d    = 1'b1;
          wrap_d    = 1'b0;
          aborted_d = 1'b0;
          if (udb_seq_cmd_op == OpLoad) begin
            state_d      = StLoad;
            load_d       = 1'b1;
            load_value_d = udb_seq_cmd_data;
            steps_d      = '0;
          end else begin
            steps_d = udb_seq_cmd_data;
            if (udb_seq_cmd_op == OpUp) begin
              direction_d = DIR_UP;
            end else if (udb_seq_cmd_op == OpDown) begin
              direction_d = DIR_DOWN;
            end
            // A zero count skips straight to completion with no enable or wait cycles.
            if (udb_seq_cmd_data == '0) begin
              state_d = StDone;
              done_d  = 1'b1;
            end else if (udb_seq_cmd_op == OpUp || udb_seq_cmd_op == OpDown) begin
              state_d = StCount;
              en_d    = 1'b1;
            end else begin
              state_d = StHold;
            end
          end
        end
      end
      StLoad: begin
        state_d = StDone;
        done_d  = 1'b1;
      end
      StCount: begin
        // en is high for every cycle spent here, so each edge is an enabled step.
        steps_d = steps_q - WIDTH'(1);
        if (at_wrap) wrap_d = 1'b1;
        if (last_step) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else if (udb_seq_abort) begin
          state_d   = StDone;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else begin
          en_d = 1'b1;
        end
      end
      StHold: begin
        steps_d = steps_q - WIDTH'(1);
        if (last_step) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else if (udb_seq_abort) begin
          state_d   = StDone;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge udb_seq_clk or negedge udb_seq_rst) begin
    if (!udb_seq_rst) begin
      state_q      <= StIdle;
      ready_q      <= 1'b0;
      load_q       <= 1'b0;
      load_value_q <= '0;
      direction_q  <= 4'h0;
      en_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      wrap_q       <= 1'b0;
      aborted_q    <= 1'b0;
      steps_q      <= '0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      load_q       <= load_d;
      load_value_q <= load_value_d;
      direction_q  <= direction_d;
      en_q         <= en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      wrap_q       <= wrap_d;
      aborted_q    <= aborted_d;
      steps_q      <= steps_d;
    end
  end

  assign udb_seq_cmd_ready  = ready_q;
  assign udb_seq_load       = load_q;
  assign udb_seq_load_value = load_value_q;
  assign udb_seq_direction  = direction_q;
  assign udb_seq_en         = en_q;
  assign udb_seq_busy       = busy_q;
  assign udb_seq_done       = done_q;
  assign udb_seq_wrap       = wrap_q;
  assign udb_seq_aborted    = aborted_q;
  assign udb_seq_steps_left = steps_q;

endmodule

// File: doc/udb_seq.md
# udb_seq

Command sequencer for the 16-bit up/down counter with load (`udb`) in the counter/barrel-shifter datapath.
- Accepts one command at a time over a valid/ready handshake: LOAD a value, COUNT up or down for N steps, or HOLD for N cycles.
- Drives the counter's load, load-value, direction and enable inputs.
- Reports completion, wrap-around and abort status to the upstream controller.

## Interface
- `WIDTH`, 16: counter and command data width.
- `DIR_UP`, 4'h1: direction code driven for counting up.
- `DIR_DOWN`, 4'h0: direction code driven for counting down.
- `udb_seq_clk` input 1: the single clock; all logic is rising-edge.
- `udb_seq_rst` input 1: reset, asynchronous, active-low.
- `udb_seq_cmd_valid` input 1: command present.
- `udb_seq_cmd_ready` output 1: sequencer can accept a command.
- `udb_seq_cmd_op` input 2: 00 LOAD, 01 COUNT_UP, 10 COUNT_DOWN, 11 HOLD.
- `udb_seq_cmd_data` input WIDTH: load value (LOAD) or step/cycle count N (other ops).
- `udb_seq_abort` input 1: terminate an active COUNT or HOLD.
- `udb_seq_q` input WIDTH: counter output, used for wrap detection.
- `udb_seq_load` output 1: counter load strobe.
- `udb_seq_load_value` output WIDTH: counter load input.
- `udb_seq_direction` output 4: counter direction.
- `udb_seq_en` output 1: counter step enable; the counter holds its value while this is low.
- `udb_seq_busy` output 1: a command is in progress, from acceptance through DONE.
- `udb_seq_done` output 1: one-cycle completion pulse.
- `udb_seq_wrap` output 1: the last command crossed a wrap boundary.
- `udb_seq_aborted` output 1: the last command was aborted.
- `udb_seq_steps_left` output WIDTH: steps or cycles remaining.

## Operation
- **Registered outputs.** All outputs are registered.
- **Reset values.** State IDLE; `cmd_ready`=1 after reset release. All other outputs are 0, including `direction`=4'h0.
- **States.** IDLE, LOAD, COUNT, HOLD, DONE.
- **IDLE.**
  - `cmd_ready`=1.
  - On `cmd_valid`&`cmd_ready`, latch op and data, set `busy`=1, `cmd_ready`=0, and clear `wrap` and `aborted`.
  - LOAD goes to LOAD.
  - COUNT_UP and COUNT_DOWN go to COUNT; `direction` is set to `DIR_UP` or `DIR_DOWN` and `steps_left`=N.
  - HOLD goes to HOLD with `steps_left`=N.
  - N=0 goes directly to DONE, with no enable or wait cycles.
- **LOAD.** `load`=1 and `load_value`=data for exactly one cycle, then DONE. `load_value` holds the last loaded value afterwards.
- **COUNT.**
  - `en`=1 while `steps_left`≠0, and `steps_left` decrements on each enabled edge.
  - Each edge with `en`=1 sets sticky `wrap` if:
    - the direction is `DIR_UP` and `q`=all-ones, or
    - the direction is `DIR_DOWN` and `q`=0.
  - On the edge where `steps_left`=1: `en` goes to 0 and the state goes to DONE.
- **HOLD.** `en`=0. `steps_left` decrements each cycle; DONE follows after N cycles.
- **Abort.** Sampled only in COUNT and HOLD.
  - If `steps_left`>1 at the sampling edge: `en` goes to 0, the state goes to DONE, `aborted`=1, and `steps_left` freezes at its value minus one.
  - If `steps_left`=1: the command completes normally and `aborted`=0.
  - Ignored in IDLE, LOAD and DONE.
- **DONE.**
  - `done`=1 for one cycle; `busy`=1 during it.
  - The next state is IDLE, where `busy`=0 and `cmd_ready`=1.
  - `wrap` and `aborted` hold until the next command is accepted.
- **Direction.** `direction` holds its last value between commands.
- **Command-wide rules.**
  - `cmd_valid` while `cmd_ready`=0 is not consumed; the upstream controller holds it.
  - A command is never accepted in the DONE cycle.

## Timing
- **Handshake.** A command is accepted at edge T, i.e. `valid`&`ready` were high in the cycle before T.
- **LOAD latency.**
  - `load`=1 in cycle T..T+1.
  - Counter holds the value after edge T+1.
  - `done`=1 in cycle T+1..T+2.
  - Ready again in cycle T+2.
- **COUNT latency.**
  - `en`=1 for exactly N consecutive cycles, starting after edge T.
  - `done` follows in the cycle after the last enable.
  - Command-to-command throughput is N+2 cycles.
- **HOLD latency.** Same cycle count as COUNT, with `en`=0 throughout.
- **N=0.** `done` appears in the cycle after acceptance; `en` and `load` stay 0.
- **Reset mid-operation.** Asserting `udb_seq_rst` in any state immediately (asynchronously) forces all outputs to their reset values. The in-flight command is discarded and no `done` is generated.
- **Abort.** The abort takes effect at the sampling edge, so the last enabled cycle is the one in which abort was high.

## Test plan
- **Reset, then LOAD 16'h0015.**
  - During reset: outputs are all 0 and `cmd_ready`=0.
  - After release: `cmd_ready`=1.
  - Required response: `load` is high for 1 cycle with `load_value`=16'h0015, `done` is pulsed 1 cycle later, and `wrap`=0 and `aborted`=0.
- **COUNT_UP N=5 after LOAD 16'h0015.** `en` is high exactly 5 cycles with `direction`=4'h1; the counter ends at 16'h001A; `done`=1 and `steps_left`=0.
- **COUNT_UP across a boundary.** LOAD 16'hFFFE, then COUNT_UP N=3 -> `wrap`=1; counter ends at 16'h0001. Repeat with LOAD 0 and COUNT_DOWN N=1 -> `wrap`=1.
- **COUNT_DOWN N=10, abort in the 4th enabled cycle.** `en` is high for 4 cycles and `aborted`=1; `steps_left`=6 is held through DONE. Repeat with abort in the 10th cycle -> `aborted`=0.
- **HOLD N=4 and N=0; back-to-back commands.**
  - HOLD N=4: `en` and `load` stay 0, and `done` arrives 5 cycles after acceptance.
  - HOLD N=0: `done` arrives 1 cycle after acceptance.
  - Back-to-back: `cmd_valid` held continuously -> the next command is accepted only in IDLE, never in the DONE cycle.
- **Reset mid-COUNT.** Assert reset mid-COUNT N=100 -> outputs go to 0 immediately, with no `done`; the first command after release executes normally.
